eda_window_scan: RTL
====================

EDA_WINDOW_SCAN -- requirements
Module: eda_window_scan

Interface
REQ-001 SHALL have parameter M, default 16: image columns (j extent), power of two.
REQ-002 SHALL have parameter N, default 16: image rows (i extent), power of two.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 8: pixel bits, unsigned.
REQ-004 SHALL have parameter WINDOW_WIDTH, default 9: 3x3 window pixel count.
REQ-005 SHALL have parameter ADDR_WIDTH, default $clog2(M*N): pixel address {i,j}.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 SHALL have port clk, input, 1: rising-edge clock.
REQ-008 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1: single-cycle scan request.
REQ-010 SHALL have port busy, output, 1: high from scan accept until the done cycle, inclusive.
REQ-011 SHALL have port done, output, 1: single-cycle pulse after the last result is accepted.
REQ-012 SHALL have port center_addr, output, ADDR_WIDTH: pixel under evaluation, to the image RAM.
REQ-013 SHALL have port window_values, input, PIXEL_WIDTH*WINDOW_WIDTH: 3x3 window; MSB slice upleft, raster order, LSB slice downright; center is slice 4.
REQ-014 SHALL have port neigh_addr_valid, input, 8: bit7 upleft to bit0 downright, center excluded.
REQ-015 SHALL have port out_valid, output, 1: result available.
REQ-016 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-017 SHALL have port out_addr, output, ADDR_WIDTH: address of the result pixel.
REQ-018 SHALL have port out_class, output, 2: 0 NOT_MAX, 1 STRICT_MAX, 2 PLATEAU; 3 is never driven.
REQ-019 SHALL have port max_count, output, ADDR_WIDTH+1: STRICT_MAX plus PLATEAU results emitted in the current scan.

Function
REQ-020 SHALL implement FSM states IDLE, SCAN, DRAIN and DONE.
REQ-021 IDLE: start=1 SHALL transition to SCAN and clear the pixel counter and max_count; start SHALL be ignored in all other states.
REQ-022 center_addr SHALL equal the pixel counter, which advances in raster order with j fastest.
REQ-023 window inputs SHALL be treated as combinational on center_addr within the same cycle.
REQ-024 SCAN: when the output register is free (!out_valid or out_ready), the block SHALL load out_addr=center_addr and out_class, assert out_valid, and increment the counter.
REQ-025 Classification SHALL consider only neighbours whose valid bit is set; NOT_MAX if any valid neighbour > center; STRICT_MAX if all valid neighbours < center; otherwise PLATEAU.
REQ-026 Comparisons SHALL be unsigned and full PIXEL_WIDTH.
REQ-027 Loading pixel M*N-1 SHALL transition SCAN to DRAIN; the counter SHALL hold and SHALL NOT wrap.
REQ-028 DRAIN: on out_valid and out_ready, the block SHALL move to DONE and deassert out_valid.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 When out_valid and !out_ready, out_addr, out_class, center_addr and the counter SHALL hold.
REQ-031 The output stream SHALL sustain one result per cycle while out_ready=1; first out_valid SHALL occur 2 cycles after start.
REQ-032 max_count SHALL increment on the load of each STRICT_MAX or PLATEAU result and hold after the scan.

Reset
REQ-033 reset SHALL force state IDLE, counter 0, center_addr 0, out_valid 0, out_addr 0, out_class 0, max_count 0, busy 0 and done 0, immediately and asynchronously.
REQ-034 reset mid-scan SHALL discard partial results; the next start SHALL begin at address 0.

Configuration
REQ-035 Macro EDA_SCAN_PLATEAU_EN defined: the block SHALL classify per REQ-025.
REQ-036 Macro EDA_SCAN_PLATEAU_EN undefined: the block SHALL report equality cases as NOT_MAX, SHALL never emit PLATEAU, and SHALL not build the equality logic.

Structure
REQ-037 Package eda_pkg SHALL hold the class enum (NOT_MAX/STRICT_MAX/PLATEAU), the FSM state enum and the neighbour bit-index constants.
REQ-038 The block SHALL use sub-module eda_neigh_cmp, a combinational 8-neighbour comparator returning any_greater and any_equal.

Verification (M=N=4, out_ready=1 unless stated)
REQ-039 All pixels 0 except (1,1)=200: 16 beats; addr 5 STRICT_MAX; zero-valued pixels not adjacent to (1,1) PLATEAU; pixels adjacent to (1,1) NOT_MAX; done one cycle after the last beat.
REQ-040 Flat image of 7: with macro, 16 PLATEAU and max_count=16; without macro, 16 NOT_MAX and max_count=0.
REQ-041 (0,0)=9, rest 3, neigh_addr_valid=8'b00001011 at addr 0: addr 0 STRICT_MAX; invalid neighbour slices forced to 255 SHALL be ignored.
REQ-042 out_ready low 5 cycles after the first beat: out_addr=0 and center_addr=1 held; exactly 16 ordered beats, none lost or duplicated.
REQ-043 reset pulsed after 6 accepted beats: all outputs 0 and state IDLE; a new start yields 16 beats from addr 0.
REQ-044 start re-asserted during SCAN: ignored, no counter reset, single done pulse.

Source files
------------

// File: rtl/eda_pkg.sv
// Shared types and constants for the 3x3 local-maximum window scanner.
package eda_pkg;

  typedef enum logic [1:0] {
    NotMax    = 2'd0,
    StrictMax = 2'd1,
    Plateau   = 2'd2
  } pix_class_e;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } scan_state_e;

  // Neighbour-valid bit positions, upleft first, center excluded.
  localparam int unsigned NbUpLeft    = 7;
  localparam int unsigned NbUp        = 6;
  localparam int unsigned NbUpRight   = 5;
  localparam int unsigned NbLeft      = 4;
  localparam int unsigned NbRight     = 3;
  localparam int unsigned NbDownLeft  = 2;
  localparam int unsigned NbDown      = 1;
  localparam int unsigned NbDownRight = 0;

  localparam int unsigned NumNeigh    = 8;
  localparam int unsigned CenterSlice = 4;

  // Window slice holding a given neighbour: bits above the center skip slice 4.
  function automatic int unsigned nb_slice(input int unsigned nb);
    return (nb >= NbLeft) ? nb + 1 : nb;
  endfunction

endpackage

// File: rtl/eda_neigh_cmp.sv
// Combinational 8-neighbour comparator against the window center.
// EDA_SCAN_PLATEAU_EN builds the equality path; otherwise ties count as greater.
module eda_neigh_cmp
  import eda_pkg::*;
#(
  parameter int unsigned PixelWidth  = 8,
  parameter int unsigned WindowWidth = 9
) (
  input  logic [PixelWidth*WindowWidth-1:0] window_i,
  input  logic [NumNeigh-1:0]               valid_i,
  output logic                              any_greater_o,
  output logic                              any_equal_o
);

  logic [PixelWidth-1:0] center;
  logic [PixelWidth-1:0] pix;

  assign center = window_i[CenterSlice*PixelWidth +: PixelWidth];

  always_comb begin
    any_greater_o = 1'b0;
    any_equal_o   = 1'b0;
    pix           = '0;
    for (int unsigned nb = 0; nb < NumNeigh; nb++) begin
      pix = window_i[nb_slice(nb)*PixelWidth +: PixelWidth];
`ifdef EDA_SCAN_PLATEAU_EN
      if (valid_i[nb] && (pix > center)) any_greater_o = 1'b1;
      if (valid_i[nb] && (pix == center)) any_equal_o = 1'b1;
`else
      // Without plateau reporting a tie disqualifies the center just like a larger neighbour.
      if (valid_i[nb] && (pix >= center)) any_greater_o = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/eda_window_scan.sv
// Raster scan of an MxN image classifying each pixel against its 3x3 neighbourhood.
// Plateau reporting is enabled by defining EDA_SCAN_PLATEAU_EN.
module eda_window_scan
  import eda_pkg::*;
#(
  parameter int unsigned M            = 16,
  parameter int unsigned N            = 16,
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned WINDOW_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH   = $clog2(M*N)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic [ADDR_WIDTH-1:0]               center_addr,
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
  input  logic [7:0]                          neigh_addr_valid,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ADDR_WIDTH-1:0]               out_addr,
  output logic [1:0]                          out_class,
  output logic [ADDR_WIDTH:0]                 max_count
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(M*N - 1);

  scan_state_e           state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  out_valid_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [1:0]            out_class_q;
  logic [ADDR_WIDTH:0]   max_count_q;
  logic                  busy_q;
  logic                  done_q;

  logic       any_greater;
  logic       any_equal;
  logic       out_free;
  pix_class_e class_d;

  eda_neigh_cmp #(
    .PixelWidth (PIXEL_WIDTH),
    .WindowWidth(WINDOW_WIDTH)
  ) u_cmp (
    .window_i     (window_values),
    .valid_i      (neigh_addr_valid),
    .any_greater_o(any_greater),
    .any_equal_o  (any_equal)
  );

  always_comb begin
    class_d = StrictMax;
    if (any_greater) begin
      class_d = NotMax;
    end else if (any_equal) begin
      class_d = Plateau;
    end
  end

  assign out_free = !out_valid_q || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_class_q <= 2'd0;
      max_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StScan;
            cnt_q       <= '0;
            max_count_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        StScan: begin
          if (out_free) begin
            out_valid_q <= 1'b1;
            out_addr_q  <= cnt_q;
            out_class_q <= class_d;
            if (class_d != NotMax) max_count_q <= max_count_q + 1'b1;
            // The counter parks on the last pixel rather than wrapping.
            if (cnt_q == LastAddr) begin
              state_q <= StDrain;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StDone;
            done_q      <= 1'b1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign center_addr = cnt_q;
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
  assign out_class   = out_class_q;
  assign max_count   = max_count_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
